// File: rtl/instr_step_sequencer_if.sv
// Instruction handshake between the fetch stage and the step sequencer.
// The master offers an instruction word with instr_valid. The slave reports
// instr_ready when it can latch that word in the current cycle.
interface instr_step_sequencer_if #(
    parameter int IR_W = 6
);
    logic            instr_valid;
    logic            instr_ready;
    logic [IR_W-1:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/instr_step_sequencer.sv
// Control-step sequencer for the 4-bit CPU.
// It latches one instruction from the handshake, then walks the step count
// T0..T3 for the datapath. step[1] feeds decoder w1 and step[0] feeds w0.
// mv/mvi finish after step 01. add/sub finish after step 11.
module instr_step_sequencer #(
    parameter int IR_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    instr_step_sequencer_if.slave   bus,
    input  logic                    hold,
    output logic [1:0]              step,
    output logic [IR_W-1:0]         ir,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        retired
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;

    logic [0:0] state;
    logic [1:0] last_step;

    // The top opcode bit separates the two-step moves from the four-step ALU ops.
    assign last_step = ir[IR_W-1] ? 2'b11 : 2'b01;

    // Acceptance depends only on state and stall, so upstream sees no valid->ready path.
    assign bus.instr_ready = (state == ST_IDLE) && !hold;

    // busy comes straight from the state flop, so it is a registered output.
    assign busy = (state == ST_EXEC);

    // Sequencing state. Reset wins over everything, and hold freezes execution.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            step    <= 2'b00;
            ir      <= '0;
            done    <= 1'b0;
            retired <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        ir    <= bus.instr;
                        state <= ST_EXEC;
                        step  <= 2'b01;
                    end
                end
                ST_EXEC: begin
                    if (!hold) begin
                        if (step == last_step) begin
                            state   <= ST_IDLE;
                            step    <= 2'b00;
                            done    <= 1'b1;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            step <= step + 2'b01;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    step  <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_step_sequencer.sv
// Directed testbench for instr_step_sequencer.
// Inputs are driven 1 ns after each rising edge, and outputs are sampled
// there too. Each check compares against a hand-computed value.
module tb_instr_step_sequencer;

    localparam int IR_W  = 6;
    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic             hold;
    logic [1:0]       step;
    logic [IR_W-1:0]  ir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] retired;

    int errors;
    int checks;
    int exp_retired;

    instr_step_sequencer_if #(.IR_W(IR_W)) bus_if ();

    instr_step_sequencer #(
        .IR_W  (IR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus_if),
        .hold    (hold),
        .step    (step),
        .ir      (ir),
        .busy    (busy),
        .done    (done),
        .retired (retired)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [IR_W-1:0] word, input logic stall);
        bus_if.instr_valid = valid;
        bus_if.instr       = word;
        hold               = stall;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, add, back-to-back mv, hold, mid-op reset, counter wrap.
    initial begin
        errors      = 0;
        checks      = 0;
        exp_retired = 0;
        resetn      = 1'b0;
        applyStimulus(1'b0, 6'b000000, 1'b0);

        // Reset, then idle.
        tick();
        tick();
        resetn = 1'b1;
        checkOutput("rst_step",    32'(step),    32'd0);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_done",    32'(done),    32'd0);
        checkOutput("rst_retired", 32'(retired), 32'd0);
        checkOutput("rst_ir",      32'(ir),      32'd0);
        checkOutput("rst_ready",   32'(bus_if.instr_ready), 32'd1);
        tick();
        checkOutput("idle_busy",   32'(busy),    32'd0);

        // In IDLE, hold blocks acceptance through instr_ready.
        applyStimulus(1'b1, 6'b100110, 1'b1);
        #1;
        checkOutput("idle_hold_ready", 32'(bus_if.instr_ready), 32'd0);
        tick();
        checkOutput("idle_hold_busy",  32'(busy), 32'd0);
        checkOutput("idle_hold_ir",    32'(ir),   32'd0);

        // add accepted at edge k.
        applyStimulus(1'b1, 6'b100110, 1'b0);
        tick();
        applyStimulus(1'b0, 6'b000000, 1'b0);
        checkOutput("add_k1_step",  32'(step), 32'd1);
        checkOutput("add_k1_busy",  32'(busy), 32'd1);
        checkOutput("add_k1_ir",    32'(ir),   32'h26);
        checkOutput("add_k1_ready", 32'(bus_if.instr_ready), 32'd0);
        tick();
        checkOutput("add_k2_step",  32'(step), 32'd2);
        checkOutput("add_k2_ir",    32'(ir),   32'h26);
        tick();
        checkOutput("add_k3_step",  32'(step), 32'd3);
        checkOutput("add_k3_done",  32'(done), 32'd0);
        tick();
        exp_retired = 1;
        checkOutput("add_k4_step",    32'(step),    32'd0);
        checkOutput("add_k4_done",    32'(done),    32'd1);
        checkOutput("add_k4_busy",    32'(busy),    32'd0);
        checkOutput("add_k4_ir",      32'(ir),      32'h26);
        checkOutput("add_k4_retired", 32'(retired), 32'(exp_retired));

        // Three mv instructions, back-to-back. Valid stays high and the first accept is at edge k.
        applyStimulus(1'b1, 6'b001100, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            checkOutput("mv_step01", 32'(step), 32'd1);
            checkOutput("mv_nodone", 32'(done), 32'd0);
            tick();
            exp_retired++;
            checkOutput("mv_done",    32'(done),    32'd1);
            checkOutput("mv_ir",      32'(ir),      32'h0C);
            checkOutput("mv_retired", 32'(retired), 32'(exp_retired));
        end
        applyStimulus(1'b0, 6'b000000, 1'b0);
        tick();
        checkOutput("mv_after_done", 32'(done), 32'd0);
        checkOutput("mv_after_busy", 32'(busy), 32'd0);

        // sub accepted at edge k, with hold high for cycles k+2 and k+3.
        applyStimulus(1'b1, 6'b110001, 1'b0);
        tick();
        applyStimulus(1'b0, 6'b000000, 1'b0);
        checkOutput("sub_k1_step", 32'(step), 32'd1);
        tick();
        checkOutput("sub_k2_step", 32'(step), 32'd2);
        applyStimulus(1'b1, 6'b000000, 1'b1);
        tick();
        checkOutput("sub_k3_step", 32'(step), 32'd2);
        checkOutput("sub_k3_ir",   32'(ir),   32'h31);
        checkOutput("sub_k3_done", 32'(done), 32'd0);
        tick();
        checkOutput("sub_k4_step", 32'(step), 32'd2);
        checkOutput("sub_k4_ir",   32'(ir),   32'h31);
        applyStimulus(1'b1, 6'b011111, 1'b0);
        tick();
        applyStimulus(1'b0, 6'b000000, 1'b0);
        checkOutput("sub_k5_step", 32'(step), 32'd3);
        checkOutput("sub_k5_ir",   32'(ir),   32'h31);
        checkOutput("sub_k5_done", 32'(done), 32'd0);
        tick();
        exp_retired++;
        checkOutput("sub_k6_done",    32'(done),    32'd1);
        checkOutput("sub_k6_step",    32'(step),    32'd0);
        checkOutput("sub_k6_retired", 32'(retired), 32'(exp_retired));

        // Accept an add, then assert reset at the edge that ends cycle k+2.
        applyStimulus(1'b1, 6'b100110, 1'b0);
        tick();
        applyStimulus(1'b0, 6'b000000, 1'b0);
        checkOutput("rmid_k1_step", 32'(step), 32'd1);
        tick();
        checkOutput("rmid_k2_step", 32'(step), 32'd2);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_retired = 0;
        checkOutput("rmid_step",    32'(step),    32'd0);
        checkOutput("rmid_busy",    32'(busy),    32'd0);
        checkOutput("rmid_done",    32'(done),    32'd0);
        checkOutput("rmid_retired", 32'(retired), 32'(exp_retired));
        checkOutput("rmid_ir",      32'(ir),      32'd0);
        tick();
        checkOutput("rmid_after_done", 32'(done), 32'd0);
        checkOutput("rmid_after_busy", 32'(busy), 32'd0);

        // Run 256 mv instructions. retired goes 255 -> 0 on the last one.
        applyStimulus(1'b1, 6'b010101, 1'b0);
        for (int n = 0; n < 256; n++) begin
            tick();
            checkOutput("wrap_step01", 32'(step), 32'd1);
            tick();
            exp_retired = (exp_retired + 1) % 256;
            checkOutput("wrap_done",    32'(done),    32'd1);
            checkOutput("wrap_retired", 32'(retired), 32'(exp_retired));
        end
        applyStimulus(1'b0, 6'b000000, 1'b0);
        checkOutput("wrap_final", 32'(retired), 32'd0);
        tick();
        checkOutput("wrap_after_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
